// File: rtl/vga_pkg.sv
// vga_pkg: shared VGA constants, colour types, pixel classes and RGB565 expansion helpers
package vga_pkg;
  localparam int H_ACTIVE = 640;
  localparam int V_ACTIVE = 480;
  localparam int MAX_W = 16;
  typedef struct packed {
    logic [7:0] r;
    logic [7:0] g;
    logic [7:0] b;
  } rgb24_t;
  typedef struct packed {
    logic [MAX_W-1:0] r;
    logic [MAX_W-1:0] g;
    logic [MAX_W-1:0] b;
  } rgbw_t;
  typedef enum logic [1:0] {PX_BLANK, PX_BG, PX_IMG, PX_BORDER} px_class_t;
  function automatic logic [MAX_W-1:0] expand_ch(input logic [7:0] src, input int n, input int w);
    expand_ch = '0;
    for (int i = 0; i < MAX_W; i++)
      if (i < w) expand_ch[w-1-i] = src[n-1-(i%n)];
  endfunction
  function automatic rgbw_t rgb565_expand(input logic [15:0] pixel, input int width);
    rgb565_expand.r = expand_ch({3'b0, pixel[15:11]}, 5, width);
    rgb565_expand.g = expand_ch({2'b0, pixel[10:5]}, 6, width);
    rgb565_expand.b = expand_ch({3'b0, pixel[4:0]}, 5, width);
  endfunction
  function automatic rgbw_t rgb_scale(input rgb24_t c, input int width);
    rgb_scale.r = expand_ch(c.r, 8, width);
    rgb_scale.g = expand_ch(c.g, 8, width);
    rgb_scale.b = expand_ch(c.b, 8, width);
  endfunction
endpackage

// File: rtl/vga_delay_line.sv
// vga_delay_line: DEPTH-stage shift register with sync reset (clk, rst, d in, q out)
module vga_delay_line #(
  parameter int WIDTH = 2,
  parameter int DEPTH = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);
  logic [WIDTH-1:0] sr [DEPTH];
  always_ff @(posedge clk) begin
    if (rst) sr <= '{default: '0};
    else begin
      sr[0] <= d;
      for (int i = 1; i < DEPTH; i++) sr[i] <= sr[i-1];
    end
  end
  assign q = sr[DEPTH-1];
endmodule

// File: rtl/vga_img_window_reader.sv
// vga_img_window_reader: windowed 1x/2x frame-buffer reader; timing (DE,x_pixel,y_pixel), live window (win_x,win_y,scale2x) -> RAM (addr,rd_en,imgData) -> r/g/b_port, frame_start; VGA_WIN_BORDER_EN adds a BORDER_COLOR ring
module vga_img_window_reader
  import vga_pkg::*;
#(
  parameter int          DATA_WIDTH = 8,
  parameter int          RGB_WIDTH  = 16,
  parameter int          IMG_WIDTH  = 176,
  parameter int          IMG_HEIGHT = 240,
  parameter int          ADDR_WIDTH = $clog2(IMG_WIDTH*IMG_HEIGHT),
  parameter int          RD_LATENCY = 1,
  parameter logic [23:0] BG_COLOR   = 24'h000000
`ifdef VGA_WIN_BORDER_EN
  , parameter logic [23:0] BORDER_COLOR = 24'hFFFFFF
`endif
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  DE,
  input  logic [9:0]            x_pixel,
  input  logic [9:0]            y_pixel,
  input  logic [9:0]            win_x,
  input  logic [9:0]            win_y,
  input  logic                  scale2x,
  output logic [ADDR_WIDTH-1:0] addr,
  output logic                  rd_en,
  input  logic [RGB_WIDTH-1:0]  imgData,
  output logic [DATA_WIDTH-1:0] r_port,
  output logic [DATA_WIDTH-1:0] g_port,
  output logic [DATA_WIDTH-1:0] b_port,
  output logic                  frame_start
);
  localparam logic [11:0] W12 = 12'(IMG_WIDTH);
  localparam logic [11:0] H12 = 12'(IMG_HEIGHT);
  localparam logic [ADDR_WIDTH-1:0] W_A = ADDR_WIDTH'(IMG_WIDTH);
  localparam rgbw_t BG_W = rgb_scale(rgb24_t'(BG_COLOR), DATA_WIDTH);
`ifdef VGA_WIN_BORDER_EN
  localparam rgbw_t BD_W = rgb_scale(rgb24_t'(BORDER_COLOR), DATA_WIDTH);
`else
  localparam rgbw_t BD_W = '0;
`endif
  logic [9:0] sh_wx, sh_wy;
  logic sh_s2, armed, half, half_cur, origin, live, s2, in_x, in_y, in_win, last_col, adv, step_col, ring;
  logic [11:0] wx, wy, x12, y12, x_end, y_end, y_off;
  logic [ADDR_WIDTH-1:0] row_base, col, row_cur, col_cur;
  logic [1:0] cls_q;
  px_class_t cls, cls_d;
  rgbw_t pix;
  always_comb begin
    origin = x_pixel == '0 && y_pixel == '0;
    // the origin pixel already belongs to the new frame, so it uses the live config
    wx = {2'b0, origin ? win_x : sh_wx};
    wy = {2'b0, origin ? win_y : sh_wy};
    s2 = origin ? scale2x : sh_s2;
    x12 = {2'b0, x_pixel};
    y12 = {2'b0, y_pixel};
    x_end = wx + (s2 ? W12 << 1 : W12);
    y_end = wy + (s2 ? H12 << 1 : H12);
    y_off = y12 - wy;
    in_x = x12 >= wx && x12 < x_end;
    in_y = y12 >= wy && y12 < y_end;
    in_win = in_x && in_y;
    live = DE && (armed || origin);
    col_cur = x12 == wx ? '0 : col;
    half_cur = x12 == wx ? 1'b0 : half;
    row_cur = origin ? '0 : row_base;
    step_col = !s2 || half_cur;
    // a window clipped at the right edge still has to finish its source row at x = 639
    last_col = in_x && (x12 == x_end - 12'd1 || (x_pixel == 10'(H_ACTIVE-1) && x_end > 12'(H_ACTIVE)));
    adv = live && in_y && last_col && (!s2 || y_off[0]);
`ifdef VGA_WIN_BORDER_EN
    ring = ((x12 + 12'd1 == wx || x12 == x_end) && y12 + 12'd1 >= wy && y12 <= y_end) ||
           ((y12 + 12'd1 == wy || y12 == y_end) && x12 + 12'd1 >= wx && x12 <= x_end);
`else
    ring = 1'b0;
`endif
    cls = !live ? PX_BLANK : in_win ? PX_IMG : ring ? PX_BORDER : PX_BG;
    cls_d = px_class_t'(cls_q);
    pix = cls_d == PX_IMG ? rgb565_expand(imgData[15:0], DATA_WIDTH) :
          cls_d == PX_BG ? BG_W : cls_d == PX_BORDER ? BD_W : '0;
  end
  vga_delay_line #(.WIDTH(2), .DEPTH(RD_LATENCY+1)) u_dl (
    .clk(clk), .rst(reset), .d(cls), .q(cls_q)
  );
  always_ff @(posedge clk) begin
    if (reset) begin
      sh_wx <= '0;
      sh_wy <= '0;
      sh_s2 <= 1'b0;
      armed <= 1'b0;
      row_base <= '0;
      col <= '0;
      half <= 1'b0;
      addr <= '0;
      rd_en <= 1'b0;
      frame_start <= 1'b0;
      r_port <= '0;
      g_port <= '0;
      b_port <= '0;
    end else begin
      if (origin) begin
        sh_wx <= win_x;
        sh_wy <= win_y;
        sh_s2 <= scale2x;
        armed <= 1'b1;
      end
      if (live && in_win) begin
        col <= step_col ? col_cur + ADDR_WIDTH'(1) : col_cur;
        half <= !step_col;
        addr <= row_cur + col_cur;
      end
      row_base <= adv ? row_cur + W_A : row_cur;
      rd_en <= live && in_win;
      frame_start <= origin;
      r_port <= pix.r[DATA_WIDTH-1:0];
      g_port <= pix.g[DATA_WIDTH-1:0];
      b_port <= pix.b[DATA_WIDTH-1:0];
    end
  end
endmodule

// File: tb/tb_vga_img_window_reader.sv
// tb_vga_img_window_reader: directed table-driven bench for vga_img_window_reader
module tb_vga_img_window_reader;
  localparam logic [23:0] BG = 24'h123456;
`ifdef VGA_WIN_BORDER_EN
  localparam logic [23:0] RING = 24'hFFFFFF;
`else
  localparam logic [23:0] RING = BG;
`endif
  logic clk = 1'b0, reset = 1'b1, DE = 1'b0, scale2x = 1'b0, rd_en, frame_start;
  logic [9:0] x_pixel = '0, y_pixel = '0, win_x = '0, win_y = '0;
  logic [15:0] addr, imgData = '0;
  logic [7:0] r_port, g_port, b_port;
  int checks = 0, errors = 0;
  typedef struct {
    logic de, s2, chk, rd, fs;
    logic [9:0] wx, wy, y, xa, xb;
    logic [15:0] ad;
    logic [23:0] rgb;
  } vec_t;
  vec_t v[$];
  vga_img_window_reader #(.BG_COLOR(BG)) dut (
    .clk(clk), .reset(reset), .DE(DE), .x_pixel(x_pixel), .y_pixel(y_pixel),
    .win_x(win_x), .win_y(win_y), .scale2x(scale2x), .addr(addr), .rd_en(rd_en),
    .imgData(imgData), .r_port(r_port), .g_port(g_port), .b_port(b_port),
    .frame_start(frame_start)
  );
  always #5 clk = ~clk;
  function automatic logic [15:0] mem_val(input logic [15:0] a);
    return a == 16'd0 ? 16'hFFFF : a == 16'd1 ? 16'h0821 : a == 16'd176 ? 16'hF800 : 16'h07E0;
  endfunction
  always_ff @(posedge clk) imgData <= mem_val(addr);
  function automatic void add(input int de, s2, wx, wy, y, xa, xb, chk, rd, fs, ad, input logic [23:0] rgb);
    vec_t e;
    e.de = 1'(de); e.s2 = 1'(s2); e.wx = 10'(wx); e.wy = 10'(wy); e.y = 10'(y);
    e.xa = 10'(xa); e.xb = 10'(xb); e.chk = 1'(chk); e.rd = 1'(rd); e.fs = 1'(fs);
    e.ad = 16'(ad); e.rgb = rgb;
    v.push_back(e);
  endfunction
  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h want %h", nm, act, exp);
    end
  endtask
  task automatic drive(input logic de, input logic [9:0] x, input logic [9:0] y);
    DE = de; x_pixel = x; y_pixel = y;
    @(posedge clk); #1;
  endtask
  task automatic run_vec(input int k);
    vec_t e;
    e = v[k];
    win_x = e.wx; win_y = e.wy; scale2x = e.s2;
    for (int x = int'(e.xa); x <= int'(e.xb); x++) drive(e.de, 10'(x), e.y);
    if (e.chk) begin
      check($sformatf("v%0d rd_en", k), 32'(rd_en), 32'(e.rd));
      if (e.rd) check($sformatf("v%0d addr", k), 32'(addr), 32'(e.ad));
      check($sformatf("v%0d frame_start", k), 32'(frame_start), 32'(e.fs));
      drive(1'b0, 10'd1000, 10'd1000);
      drive(1'b0, 10'd1000, 10'd1000);
      check($sformatf("v%0d rgb", k), 32'({r_port, g_port, b_port}), 32'(e.rgb));
    end
  endtask
  initial begin
    int mark;
    // frame A: 1x window at (100,50)
    add(1,0,100,50,  0,  0,  0,1,0,1,  0,BG);
    add(1,0,100,50, 49,100,100,1,0,0,  0,RING);
    add(1,0,100,50, 50, 99, 99,1,0,0,  0,RING);
    add(1,0,100,50, 50,100,100,1,1,0,  0,24'hFFFFFF);
    add(1,0,100,50, 50,101,101,1,1,0,  1,24'h080408);
    add(1,0,100,50, 50,102,275,1,1,0,175,24'h00FF00);
    add(1,0,100,50, 50,276,276,1,0,0,  0,RING);
    add(1,0,100,50, 51, 50, 50,1,0,0,  0,BG);
    add(1,0,100,50, 51, 99, 99,1,0,0,  0,RING);
    add(1,0,100,50, 51,100,100,1,1,0,176,24'hFF0000);
    add(1,0,100,50,290,100,100,1,0,0,  0,RING);
    add(0,0,100,50, 60,150,150,1,0,0,  0,24'h000000);
    // frame B: 2x window at (0,0)
    add(1,1,0,0,0,0,  0,1,1,1,  0,24'hFFFFFF);
    add(1,1,0,0,0,1,  1,1,1,0,  0,24'hFFFFFF);
    add(1,1,0,0,0,2,  2,1,1,0,  1,24'h080408);
    add(1,1,0,0,1,0,  0,1,1,0,  0,24'hFFFFFF);
    add(1,1,0,0,1,1,  1,1,1,0,  0,24'hFFFFFF);
    add(1,1,0,0,1,2,351,1,1,0,175,24'h00FF00);
    add(1,1,0,0,2,0,  0,1,1,0,176,24'hFF0000);
    add(1,1,0,0,2,1,  1,1,1,0,176,24'hFF0000);
    mark = v.size();
    add(1,1,0,0,479,  0,351,1,1,0,42239,24'h00FF00);
    add(1,1,0,0,479,352,352,1,0,0,    0,RING);
    // frame C: 2x window clipped at win_x = 500, then a live change mid-frame
    add(1,1,500,0,0,  0,  0,1,0,1,  0,BG);
    add(1,1,500,0,0,500,639,1,1,0, 69,24'h00FF00);
    add(1,1,500,0,1,500,639,1,1,0, 69,24'h00FF00);
    add(1,1,500,0,2,500,500,1,1,0,176,24'hFF0000);
    add(1,1,500,0,2,501,639,1,1,0,245,24'h00FF00);
    add(1,0,100,0,4,100,100,1,0,0,  0,BG);
    add(1,0,100,0,4,500,500,1,1,0,176,24'hFF0000);
    // frame D: the new config takes effect at the origin
    add(1,0,100,0,0,  0,  0,1,0,1,  0,BG);
    add(1,0,100,0,0,100,100,1,1,0,  0,24'hFFFFFF);
    add(1,0,100,0,0,101,150,1,1,0, 50,24'h00FF00);
    repeat (3) @(posedge clk);
    #1;
    check("reset addr", 32'(addr), 32'd0);
    check("reset rd_en", 32'(rd_en), 32'd0);
    check("reset rgb", 32'({r_port, g_port, b_port}), 32'd0);
    check("reset frame_start", 32'(frame_start), 32'd0);
    reset = 1'b0;
    for (int k = 0; k < mark; k++) run_vec(k);
    for (int y = 3; y <= 477; y += 2) drive(1'b1, 10'd351, 10'(y));
    for (int k = mark; k < v.size(); k++) run_vec(k);
    DE = 1'b1; x_pixel = 10'd151; y_pixel = 10'd0; reset = 1'b1;
    @(posedge clk); #1;
    check("midreset addr", 32'(addr), 32'd0);
    check("midreset rd_en", 32'(rd_en), 32'd0);
    check("midreset rgb", 32'({r_port, g_port, b_port}), 32'd0);
    check("midreset frame_start", 32'(frame_start), 32'd0);
    reset = 1'b0;
    drive(1'b1, 10'd152, 10'd0);
    check("postreset rd_en", 32'(rd_en), 32'd0);
    drive(1'b0, 10'd1000, 10'd1000);
    drive(1'b0, 10'd1000, 10'd1000);
    check("postreset rgb", 32'({r_port, g_port, b_port}), 32'd0);
    drive(1'b1, 10'd0, 10'd0);
    check("rearm frame_start", 32'(frame_start), 32'd1);
    drive(1'b1, 10'd100, 10'd0);
    check("rearm frame_start low", 32'(frame_start), 32'd0);
    check("rearm rd_en", 32'(rd_en), 32'd1);
    check("rearm addr", 32'(addr), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
